// File: rtl/sram_read_streamer_if.sv
// Bundle of the command, SRAM request/return and output stream signals for sram_read_streamer.
// Macro SRAM_RD_STREAM_STRIDE_EN adds the cmd_stride field.
interface sram_read_streamer_if #(
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH       = 16
);
    // Every valid/ready pair transfers on a cycle where both are high at the clock edge.
    // A source holds its payload stable while valid is high and ready is low.
    // mem_rdata_valid is a strobe with no ready.
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [SRAM_ADDR_WIDTH-1:0] cmd_base_addr;
    logic [LEN_WIDTH-1:0]       cmd_len;
`ifdef SRAM_RD_STREAM_STRIDE_EN
    logic [SRAM_ADDR_WIDTH-1:0] cmd_stride;
`endif
    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic                       mem_req_wen;
    logic [SRAM_ADDR_WIDTH-1:0] mem_req_addr;
    logic [SRAM_DATA_WIDTH-1:0] mem_req_wdata;
    logic [SRAM_DATA_WIDTH-1:0] mem_rdata;
    logic                       mem_rdata_valid;
    logic                       out_valid;
    logic                       out_ready;
    logic [SRAM_DATA_WIDTH-1:0] out_data;
    logic                       out_last;

    // Streamer side.
    modport master (
`ifdef SRAM_RD_STREAM_STRIDE_EN
        input  cmd_stride,
`endif
        input  cmd_valid, cmd_base_addr, cmd_len,
        output cmd_ready,
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_rdata, mem_rdata_valid,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    // Command source, arbiter and stream consumer side.
    modport slave (
`ifdef SRAM_RD_STREAM_STRIDE_EN
        output cmd_stride,
`endif
        output cmd_valid, cmd_base_addr, cmd_len,
        input  cmd_ready,
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_rdata, mem_rdata_valid,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/sram_read_streamer.sv
// Command-driven SRAM read sequencer: issues one read per word, buffers returns in a credit-protected FIFO.
// Optional macro SRAM_RD_STREAM_STRIDE_EN: latch a per-command cmd_stride (otherwise stride is 1).
module sram_read_streamer #(
    parameter int SRAM_DATA_WIDTH = 32,
    parameter int SRAM_ADDR_WIDTH = 16,
    parameter int LEN_WIDTH       = 16,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sram_read_streamer_if.master bus,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [1:0]           state_dbg
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_CREDIT = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                     state;
    logic                       cmd_ready_q;
    logic [SRAM_ADDR_WIDTH-1:0] addr;
    logic [SRAM_ADDR_WIDTH-1:0] stride;
    logic [LEN_WIDTH-1:0]       remaining;
    logic [LEN_WIDTH-1:0]       len_q;
    logic [LEN_WIDTH-1:0]       received;
    logic [CNT_W-1:0]           outstanding;

    logic [SRAM_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic                       fifo_last [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           fifo_count;

    logic req_valid;
    logic grant;
    logic ret_ok;
    logic pop;
    logic push_last;
    logic head_last;

    // Credit rule: a read is only issued if its return is guaranteed a FIFO slot.
    assign req_valid = (state == ISSUE) && (remaining != '0) &&
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_CREDIT);
    assign grant     = req_valid && bus.mem_req_ready;
    assign ret_ok    = bus.mem_rdata_valid && (outstanding != '0);
    assign pop       = (fifo_count != '0) && bus.out_ready;
    assign push_last = ((received + LEN_WIDTH'(1)) == len_q);
    assign head_last = fifo_last[rd_ptr];

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.mem_req_valid = req_valid;
    assign bus.mem_req_wen   = 1'b0;
    assign bus.mem_req_addr  = addr;
    assign bus.mem_req_wdata = '0;
    assign bus.out_valid     = (fifo_count != '0);
    assign bus.out_data      = fifo_data[rd_ptr];
    assign bus.out_last      = head_last && (fifo_count != '0);
    assign state_dbg         = state;

`ifndef SRAM_RD_STREAM_STRIDE_EN
    assign stride = SRAM_ADDR_WIDTH'(1);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            addr        <= '0;
            remaining   <= '0;
            len_q       <= '0;
            received    <= '0;
            outstanding <= '0;
`ifdef SRAM_RD_STREAM_STRIDE_EN
            stride      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        err <= 1'b0;
                        if (bus.cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            addr        <= bus.cmd_base_addr;
                            remaining   <= bus.cmd_len;
                            len_q       <= bus.cmd_len;
                            received    <= '0;
`ifdef SRAM_RD_STREAM_STRIDE_EN
                            stride      <= bus.cmd_stride;
`endif
                            state       <= ISSUE;
                            cmd_ready_q <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (grant) begin
                        addr      <= addr + stride;
                        remaining <= remaining - LEN_WIDTH'(1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && head_last) begin
                        state       <= IDLE;
                        cmd_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready_q <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase

            // Returns are never stalled; a return with nothing in flight is a stray (e.g. after reset).
            if (ret_ok) begin
                received <= received + LEN_WIDTH'(1);
            end else if (bus.mem_rdata_valid) begin
                err <= 1'b1;
            end

            case ({grant, ret_ok})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (ret_ok) begin
                fifo_data[wr_ptr] <= bus.mem_rdata;
                fifo_last[wr_ptr] <= push_last;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({ret_ok, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_read_streamer.sv
// Bench for sram_read_streamer: 2-cycle arbiter model, vector table of commands, scoreboard of expected words.
// Honours SRAM_RD_STREAM_STRIDE_EN when defined.
module tb_sram_read_streamer;
    localparam int DW    = 32;
    localparam int AW    = 16;
    localparam int LW    = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] state_dbg;

    sram_read_streamer_if #(.SRAM_DATA_WIDTH(DW), .SRAM_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    sram_read_streamer #(
        .SRAM_DATA_WIDTH(DW),
        .SRAM_ADDR_WIDTH(AW),
        .LEN_WIDTH      (LW),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- scoreboard state ----------------
    logic [DW-1:0] exp_q[$];
    logic          exp_last_q[$];
    logic [AW-1:0] exp_addr_q[$];

    int n_cmp = 0;
    int n_err = 0;

    int      rdy_mode = 0;   // 0 always, 1 toggle 1010, 2 random
    int      ordy_mode = 0;  // 0 always, 1 random, 2 held low
    int      grants, first_valid_cyc, last_pop_cyc, done_cyc, done_count;
    int      reqv_seen, busy_seen, outv_seen;
    logic [AW-1:0] last_grant_addr;

    typedef struct {
        logic [AW-1:0] base;
        logic [LW-1:0] len;
        int            rdy_mode;
        int            ordy_mode;
        int            exp_grants;
        logic [AW-1:0] exp_last_addr;
    } vec_t;

    function automatic logic [DW-1:0] word_of(input logic [AW-1:0] a);
        return {a ^ 16'hC3A5, a};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // ---------------- arbiter model + output monitor ----------------
    initial begin : bus_model
        logic          g;
        logic          tog;
        logic          l;
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic          pipe_v [2];
        logic [DW-1:0] pipe_d [2];
        logic          prev_stall;
        logic [AW-1:0] prev_addr;
        tog = 1'b0;
        prev_stall = 1'b0;
        prev_addr = '0;
        pipe_v[0] = 1'b0; pipe_v[1] = 1'b0;
        pipe_d[0] = '0;   pipe_d[1] = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.mem_rdata = '0;
        bus.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       bus.mem_req_ready = 1'b1;
                1:       begin tog = ~tog; bus.mem_req_ready = tog; end
                default: bus.mem_req_ready = 1'($urandom_range(0, 1));
            endcase
            case (ordy_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = 1'b0;
            endcase
            g = 1'b0;
            if (rst_n) begin
                if (prev_stall) begin
                    check("addr_hold_valid", 32'(bus.mem_req_valid), 32'd1);
                    check("addr_hold", 32'(bus.mem_req_addr), 32'(prev_addr));
                end
                g = bus.mem_req_valid && bus.mem_req_ready;
                if (g) begin
                    grants++;
                    last_grant_addr = bus.mem_req_addr;
                    if (exp_addr_q.size() == 0) fail_now("unexpected_grant");
                    else begin
                        a = exp_addr_q.pop_front();
                        check("req_addr", 32'(bus.mem_req_addr), 32'(a));
                    end
                    check("req_wen", 32'(bus.mem_req_wen), 32'd0);
                end
                prev_stall = bus.mem_req_valid && !bus.mem_req_ready;
                prev_addr  = bus.mem_req_addr;
                if (bus.out_valid) begin
                    outv_seen = 1;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) fail_now("unexpected_word");
                    else begin
                        d = exp_q.pop_front();
                        l = exp_last_q.pop_front();
                        check("out_data", bus.out_data, d);
                        check("out_last", 32'(bus.out_last), 32'(l));
                        if (l) last_pop_cyc = cyc;
                    end
                end
                if (done) begin
                    done_count++;
                    done_cyc = cyc;
                end
                if (bus.mem_req_valid) reqv_seen = 1;
                if (busy) busy_seen = 1;
            end else begin
                prev_stall = 1'b0;
            end
            // Returns for grants made two cycles earlier; this pipeline survives a DUT reset.
            bus.mem_rdata_valid = pipe_v[1];
            bus.mem_rdata       = pipe_d[1];
            pipe_v[1] = pipe_v[0];
            pipe_d[1] = pipe_d[0];
            pipe_v[0] = g;
            pipe_d[0] = word_of(bus.mem_req_addr);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_cmd(input logic [AW-1:0] base, input logic [LW-1:0] len,
                             input logic [AW-1:0] stride, input int rm, input int om,
                             output int acc);
        logic [AW-1:0] a;
        int n;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i) * stride;
            exp_addr_q.push_back(a);
            exp_q.push_back(word_of(a));
            exp_last_q.push_back(i == int'(len) - 1);
        end
        grants = 0; first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1; done_count = 0;
        reqv_seen = 0; busy_seen = 0; outv_seen = 0;
        rdy_mode = rm;
        ordy_mode = om;
        bus.cmd_base_addr = base;
        bus.cmd_len = len;
`ifdef SRAM_RD_STREAM_STRIDE_EN
        bus.cmd_stride = stride;
`endif
        bus.cmd_valid = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 50) begin
            tick();
            n++;
        end
        check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        acc = cyc;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input logic [LW-1:0] len, input int acc, input logic chk_lat);
        int n;
        n = 0;
        while (done_count == 0 && n < 3000) begin
            tick();
            n++;
        end
        check("done_seen", 32'(done_count != 0), 32'd1);
        repeat (3) tick();
        check("done_once", 32'(done_count), 32'd1);
        check("busy_idle", 32'(busy), 32'd0);
        check("cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        check("words_left", 32'(exp_q.size()), 32'd0);
        check("addrs_left", 32'(exp_addr_q.size()), 32'd0);
        if (len != '0) begin
            check("done_after_last", 32'(done_cyc), 32'(last_pop_cyc + 1));
            if (chk_lat) check("first_latency", 32'(first_valid_cyc - acc), 32'd4);
        end else begin
            check("len0_done", 32'(done_cyc), 32'(acc + 1));
            check("len0_noreq", 32'(reqv_seen), 32'd0);
            check("len0_busy", 32'(busy_seen), 32'd0);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        check({tag, "_req_valid"}, 32'(bus.mem_req_valid), 32'd0);
        check({tag, "_req_addr"}, 32'(bus.mem_req_addr), 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, bus.out_data, 32'd0);
        check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin : main
        vec_t vecs [6];
        int   acc;
        int   n;
        vecs[0] = '{16'h0800, 16'd4,  0, 0, 4,  16'h0803};
        vecs[1] = '{16'h1234, 16'd5,  1, 0, 5,  16'h1238};
        vecs[2] = '{16'hFFFE, 16'd4,  0, 0, 4,  16'h0001};
        vecs[3] = '{16'h0100, 16'd16, 2, 1, 16, 16'h010F};
        vecs[4] = '{16'h2000, 16'd1,  0, 0, 1,  16'h2000};
        vecs[5] = '{16'h3000, 16'd7,  0, 1, 7,  16'h3006};

        bus.cmd_valid = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_len = '0;
`ifdef SRAM_RD_STREAM_STRIDE_EN
        bus.cmd_stride = '0;
`endif
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check_reset("por");
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            start_cmd(vecs[i].base, vecs[i].len, 16'h0001, vecs[i].rdy_mode, vecs[i].ordy_mode, acc);
            finish_cmd(vecs[i].len, acc, vecs[i].rdy_mode == 0);
            check("tbl_grants", 32'(grants), 32'(vecs[i].exp_grants));
            check("tbl_last_addr", 32'(last_grant_addr), 32'(vecs[i].exp_last_addr));
            check("tbl_err", 32'(err), 32'd0);
        end

        // Empty command.
        start_cmd(16'h5555, 16'd0, 16'h0001, 0, 0, acc);
        finish_cmd(16'd0, acc, 1'b1);

        // Consumer held off: credits cap issue at the FIFO depth.
        start_cmd(16'h0400, 16'd8, 16'h0001, 0, 2, acc);
        repeat (20) tick();
        check("stall_grants", 32'(grants), 32'(DEPTH));
        check("stall_req_low", 32'(bus.mem_req_valid), 32'd0);
        check("stall_out_valid", 32'(bus.out_valid), 32'd1);
        ordy_mode = 0;
        finish_cmd(16'd8, acc, 1'b1);
        check("stall_total_grants", 32'(grants), 32'd8);

`ifdef SRAM_RD_STREAM_STRIDE_EN
        start_cmd(16'h0000, 16'd4, 16'h0800, 0, 0, acc);
        finish_cmd(16'd4, acc, 1'b1);
        check("stride_last_addr", 32'(last_grant_addr), 32'h1800);
        start_cmd(16'h0123, 16'd3, 16'h0000, 1, 0, acc);
        finish_cmd(16'd3, acc, 1'b0);
        check("stride0_last_addr", 32'(last_grant_addr), 32'h0123);
`endif

        // Reset with two reads still inside the arbiter pipeline.
        start_cmd(16'h4000, 16'd8, 16'h0001, 0, 0, acc);
        n = 0;
        while (grants < 2 && n < 20) begin
            tick();
            n++;
        end
        check("inflight_two", 32'(grants), 32'd2);
        rst_n = 1'b0;
        #1;
        check_reset("mid");
        rst_n = 1'b1;
        exp_q.delete();
        exp_last_q.delete();
        exp_addr_q.delete();
        outv_seen = 0; reqv_seen = 0; done_count = 0;
        repeat (6) tick();
        check("late_err", 32'(err), 32'd1);
        check("late_no_out", 32'(outv_seen), 32'd0);
        check("late_no_req", 32'(reqv_seen), 32'd0);
        check("late_no_done", 32'(done_count), 32'd0);

        // Next command clears the sticky error.
        start_cmd(16'h0010, 16'd2, 16'h0001, 0, 0, acc);
        check("err_cleared", 32'(err), 32'd0);
        finish_cmd(16'd2, acc, 1'b1);
        check("post_err", 32'(err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sram_read_streamer.md
# sram_read_streamer

Command-driven read sequencer for the compute port of the banked SRAM arbiter. It accepts a {base, length} read command and issues one read per word to the arbiter's valid/ready request port. It tracks reads in flight against the arbiter's fixed 2-cycle read latency and buffers returned words in a credit-protected FIFO. Words are delivered as a valid/ready stream with a last flag, so compute back-pressure never overflows the buffer.

## Interface
- SRAM_DATA_WIDTH, 32, word width
- SRAM_ADDR_WIDTH, 16, flat SRAM address width {bank_id, bank_offset}
- LEN_WIDTH, 16, command length field width (words)
- FIFO_DEPTH, 4, return buffer entries; power of two, >=2; >=4 needed for full rate

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both high; high only in IDLE
- cmd_base_addr  in  SRAM_ADDR_WIDTH  first word address
- cmd_len  in  LEN_WIDTH  word count; 0 = empty command
- cmd_stride  in  SRAM_ADDR_WIDTH  address increment (present only with macro)
- mem_req_valid  out  1  read request to arbiter
- mem_req_ready  in  1  arbiter grant
- mem_req_wen  out  1  tied 0
- mem_req_addr  out  SRAM_ADDR_WIDTH  request address
- mem_req_wdata  out  SRAM_DATA_WIDTH  tied 0
- mem_rdata  in  SRAM_DATA_WIDTH  returned data
- mem_rdata_valid  in  1  returned data strobe
- out_valid / out_ready  out / in  1  output stream handshake
- out_data  out  SRAM_DATA_WIDTH  FIFO head data
- out_last  out  1  head is final word of command
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse at command completion
- err  out  1  sticky: rdata_valid with zero reads in flight; cleared on next command accept

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: cmd_ready=1.
  - Accept with cmd_len=0: no requests issued; done pulses the next cycle; stay IDLE.
  - Accept with cmd_len>0: load addr=cmd_base_addr, remaining=cmd_len, received=0; clear err; go to ISSUE.
- ISSUE:
  - mem_req_valid = (remaining!=0) && (outstanding + fifo_count < FIFO_DEPTH).
  - On valid&&ready: addr += stride (mod 2^SRAM_ADDR_WIDTH, wraps silently), remaining--, outstanding++.
  - After the last issue, go to DRAIN.
  - mem_req_addr must remain stable while valid is high and not granted.
- Return path (all states):
  - mem_rdata_valid with outstanding>0: push {mem_rdata, last = (received+1 == len)}; outstanding--; received++.
  - mem_rdata_valid with outstanding==0: data dropped, err set.
  - Issue and return in the same cycle leave outstanding unchanged.
- Output: out_valid = fifo_count!=0. Pop on out_valid&&out_ready. Push and pop in the same cycle are allowed at any count. The credit rule guarantees a push never hits a full FIFO.
- DRAIN: when the word tagged last is popped, pulse done and go to IDLE (done and cmd_ready high in the following cycle).
- No abort. Reset mid-command clears all state; reads still in the arbiter pipeline return with outstanding==0, are dropped and set err.

## Timing
- Reset values: cmd_ready=1, mem_req_valid=0, mem_req_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, err=0.
- Command accepted at edge T: mem_req_valid can first be high in cycle T+1.
- Request granted in cycle C: arbiter returns rdata_valid in cycle C+2; pushed at the end of C+2; out_valid high in C+3.
- First-word latency from command accept edge to out_valid is 4 cycles, given ready=1 everywhere.
- Throughput: 1 word/cycle with FIFO_DEPTH>=4 and out_ready=1. FIFO_DEPTH=2 stalls issue to 2 words per 3 cycles.
- mem_req_ready low stalls issue only. Returns are never stalled.

## Configuration
- SRAM_RD_STREAM_STRIDE_EN defined: cmd_stride port exists and is latched on command accept; a stride of 0 re-reads one address.
- Not defined: no cmd_stride port; stride is fixed at 1.

## Test plan
- Base 0x0800, len 4, ready always, arbiter model with 2-cycle latency -> addresses 0x0800..0x0803; first out_valid 4 cycles after accept; 4 consecutive words, out_last on the 4th; done 1 cycle after last pop.
- len 0 -> no mem_req_valid; done pulses the cycle after accept; busy stays 0.
- len 8, out_ready held low -> exactly FIFO_DEPTH (4) grants, then mem_req_valid=0; release out_ready -> remaining 4 issued, all 8 words in order, none lost.
- mem_req_ready toggling 1010..., len 5 -> mem_req_addr held stable while stalled; 5 words correct; done once.
- Base 0xFFFE, len 4 (with macro, stride 1) -> addresses FFFE, FFFF, 0000, 0001; with macro, stride 0x0800 from 0x0000 -> 0x0000, 0x0800, 0x1000, 0x1800.
- Assert rst_n mid-command with 2 reads in flight -> all outputs at reset values; the two late rdata_valid pulses set err and produce no out_valid.
